// File: rtl/riscv_defines.sv
// Shared pipeline type definitions: memory access kinds and store-data
// forwarding source selector used by store_data_forward_unit.
package riscv_defines;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } memaccess_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_W    = 2'd1,
        FWD_HOLD = 2'd2,
        FWD_HIST = 2'd3
    } fwd_src_t;

endpackage

// File: rtl/store_fwd_history.sv
// Shift register of the last HIST_DEPTH writebacks (entry 0 = youngest),
// with a lookup that returns the youngest valid entry matching a register.
module store_fwd_history
    import riscv_defines::*;
#(
    parameter int XLEN       = 32,
    parameter int HIST_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_valid_i,
    input  logic [REG_ADDR_W-1:0] push_rd_i,
    input  logic [XLEN-1:0]       push_data_i,
    input  logic [REG_ADDR_W-1:0] lookup_rd_i,
    output logic                  hit_o,
    output logic [XLEN-1:0]       hit_data_o
);

    logic [HIST_DEPTH-1:0] valid_q;
    logic [REG_ADDR_W-1:0] rd_q   [HIST_DEPTH];
    logic [XLEN-1:0]       data_q [HIST_DEPTH];

    // Shift every cycle; x0 writes never become valid entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= push_valid_i && (push_rd_i != '0);
            rd_q[0]    <= push_rd_i;
            data_q[0]  <= push_data_i;
            for (int unsigned i = 1; i < HIST_DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                rd_q[i]    <= rd_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    // Scan oldest to youngest so the lowest-index match wins.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
            if (valid_q[HIST_DEPTH-1-i] && (lookup_rd_i != '0) &&
                (rd_q[HIST_DEPTH-1-i] == lookup_rd_i)) begin
                hit_o      = 1'b1;
                hit_data_o = data_q[HIST_DEPTH-1-i];
            end
        end
    end

endmodule

// File: rtl/store_data_forward_unit.sv
// Resolves store data for the M1 stage: W-stage bypass, a hold register that
// pins forwarded data across a stall, and (with STORE_FWD_HISTORY_EN defined)
// a short history of past writebacks.
module store_data_forward_unit
    import riscv_defines::*;
#(
    parameter int XLEN       = 32,
    parameter int HIST_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  memaccess_t            memaccess_m1,
    input  logic                  stall_m1,
    input  logic                  flush_m1,
    input  logic [REG_ADDR_W-1:0] rs2_m1,
    input  logic [XLEN-1:0]       rs2_data_m1,
    input  logic                  regwrite_w,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic [XLEN-1:0]       result_w,
    output logic [XLEN-1:0]       store_data_m1,
    output logic                  forward_m1,
    output logic                  flag,
    output fwd_src_t              fwd_src
);

    logic            hold_valid_q, hold_valid_d;
    logic [XLEN-1:0] hold_data_q, hold_data_d;
    logic            hist_hit;
    logic [XLEN-1:0] hist_data;
    logic            active;
    logic            w_hit;

`ifdef STORE_FWD_HISTORY_EN
    store_fwd_history #(
        .XLEN       (XLEN),
        .HIST_DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk          (clk),
        .reset        (reset),
        .push_valid_i (regwrite_w),
        .push_rd_i    (rd_w),
        .push_data_i  (result_w),
        .lookup_rd_i  (rs2_m1),
        .hit_o        (hist_hit),
        .hit_data_o   (hist_data)
    );
`else
    logic unused_hist_cfg;
    assign unused_hist_cfg = (HIST_DEPTH > 0);
    assign hist_hit        = 1'b0;
    assign hist_data       = '0;
`endif

    // Source selection; held and historical state read as empty during reset.
    always_comb begin
        active  = (memaccess_m1 == MEM_WRITE) && !flush_m1;
        w_hit   = regwrite_w && (rd_w != '0) && (rd_w == rs2_m1);
        fwd_src = FWD_NONE;
        if (active) begin
            if (w_hit)
                fwd_src = FWD_W;
            else if (hold_valid_q && !reset)
                fwd_src = FWD_HOLD;
            else if (hist_hit && !reset && (rs2_m1 != '0))
                fwd_src = FWD_HIST;
        end
    end

    // Data mux and hazard indications follow the selected source.
    always_comb begin
        case (fwd_src)
            FWD_W:    store_data_m1 = result_w;
            FWD_HOLD: store_data_m1 = hold_data_q;
            FWD_HIST: store_data_m1 = hist_data;
            default:  store_data_m1 = rs2_data_m1;
        endcase
        forward_m1 = (fwd_src != FWD_NONE);
        flag       = forward_m1;
    end

    // Hold next state: clear beats load; a fresh W hit replaces held data.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (!active || !stall_m1) begin
            hold_valid_d = 1'b0;
        end else if ((fwd_src == FWD_W) || (fwd_src == FWD_HIST)) begin
            hold_valid_d = 1'b1;
            hold_data_d  = store_data_m1;
        end
    end

    // Hold register state.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end

endmodule

// File: tb/tb_store_data_forward_unit.sv
// Directed bench for store_data_forward_unit; expectations adapt to whether
// STORE_FWD_HISTORY_EN is defined for the build.
module tb_store_data_forward_unit;
    import riscv_defines::*;

    localparam int XLEN = 32;
    localparam int HD   = 2;
`ifdef STORE_FWD_HISTORY_EN
    localparam bit HIST_ON = 1'b1;
`else
    localparam bit HIST_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    memaccess_t      memaccess_m1;
    logic            stall_m1, flush_m1;
    logic [4:0]      rs2_m1;
    logic [XLEN-1:0] rs2_data_m1;
    logic            regwrite_w;
    logic [4:0]      rd_w;
    logic [XLEN-1:0] result_w;
    logic [XLEN-1:0] store_data_m1;
    logic            forward_m1, flag;
    fwd_src_t        fwd_src;

    always #5 clk = ~clk;

    store_data_forward_unit #(.XLEN(XLEN), .HIST_DEPTH(HD)) dut (
        .clk           (clk),
        .reset         (reset),
        .memaccess_m1  (memaccess_m1),
        .stall_m1      (stall_m1),
        .flush_m1      (flush_m1),
        .rs2_m1        (rs2_m1),
        .rs2_data_m1   (rs2_data_m1),
        .regwrite_w    (regwrite_w),
        .rd_w          (rd_w),
        .result_w      (result_w),
        .store_data_m1 (store_data_m1),
        .forward_m1    (forward_m1),
        .flag          (flag),
        .fwd_src       (fwd_src)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference model: list of recent writebacks (newest first) and a hold slot.
    typedef struct {
        bit              v;
        bit [4:0]        rd;
        bit [XLEN-1:0]   d;
    } wb_t;
    wb_t             wb_hist[$];
    bit              m_hold_v = 1'b0;
    logic [XLEN-1:0] m_hold_d = '0;

    function automatic void model_eval(output fwd_src_t s, output logic [XLEN-1:0] d);
        bit is_store;
        bit found;
        logic [XLEN-1:0] hd;
        is_store = (memaccess_m1 == MEM_WRITE) && !flush_m1;
        found = 1'b0;
        hd = '0;
        if (HIST_ON && !reset && rs2_m1 != 0) begin
            foreach (wb_hist[i]) begin
                if (!found && wb_hist[i].v && wb_hist[i].rd == rs2_m1) begin
                    found = 1'b1;
                    hd = wb_hist[i].d;
                end
            end
        end
        s = FWD_NONE;
        d = rs2_data_m1;
        if (!is_store) return;
        if (regwrite_w && rd_w != 0 && rd_w == rs2_m1) begin
            s = FWD_W; d = result_w;
        end else if (m_hold_v && !reset) begin
            s = FWD_HOLD; d = m_hold_d;
        end else if (found) begin
            s = FWD_HIST; d = hd;
        end
    endfunction

    always @(posedge clk) begin
        fwd_src_t s;
        logic [XLEN-1:0] d;
        wb_t e;
        if (reset) begin
            wb_hist.delete();
            m_hold_v = 1'b0;
            m_hold_d = '0;
        end else begin
            model_eval(s, d);
            if (!((memaccess_m1 == MEM_WRITE) && !flush_m1) || !stall_m1) begin
                m_hold_v = 1'b0;
            end else if (s == FWD_W || s == FWD_HIST) begin
                m_hold_v = 1'b1;
                m_hold_d = d;
            end
            e.v  = regwrite_w && (rd_w != 0);
            e.rd = rd_w;
            e.d  = result_w;
            wb_hist.push_front(e);
            while (wb_hist.size() > HD) void'(wb_hist.pop_back());
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        fwd_src_t es;
        logic [XLEN-1:0] ed;
        if (cmp_en) begin
            model_eval(es, ed);
            checks++;
            if (fwd_src !== es || store_data_m1 !== ed ||
                forward_m1 !== (es != FWD_NONE) || flag !== (es != FWD_NONE)) begin
                errors++;
                $display("FAIL model t=%0t: got src=%s data=%h fwd=%b flag=%b, want src=%s data=%h",
                         $time, fwd_src.name(), store_data_m1, forward_m1, flag, es.name(), ed);
            end
        end
    end

    task automatic set(input logic r, input memaccess_t m, input logic st, input logic fl,
                       input logic [4:0] rs2, input logic [XLEN-1:0] rs2d,
                       input logic rw, input logic [4:0] rd, input logic [XLEN-1:0] res);
        reset = r; memaccess_m1 = m; stall_m1 = st; flush_m1 = fl;
        rs2_m1 = rs2; rs2_data_m1 = rs2d; regwrite_w = rw; rd_w = rd; result_w = res;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input fwd_src_t es, input logic [XLEN-1:0] ed);
        #3;
        checks++;
        if (fwd_src !== es || store_data_m1 !== ed ||
            forward_m1 !== (es != FWD_NONE) || flag !== (es != FWD_NONE)) begin
            errors++;
            $display("FAIL %s: got src=%s data=%h fwd=%b flag=%b, want src=%s data=%h",
                     name, fwd_src.name(), store_data_m1, forward_m1, flag, es.name(), ed);
        end
    endtask

    initial begin
        set(1, MEM_NONE, 0, 0, 0, '0, 0, 0, '0);
        cmp_en = 1'b1;
        cyc(); cyc();

        set(1, MEM_WRITE, 0, 0, 5, 32'hDEAD, 0, 0, '0);
        lit("reset_state", FWD_NONE, 32'hDEAD); cyc();

        set(0, MEM_WRITE, 0, 0, 5, 32'h0, 1, 5, 32'h1234);
        lit("w_hit", FWD_W, 32'h1234); cyc();

        set(0, MEM_NONE, 0, 0, 0, '0, 1, 6, 32'hAA); cyc();
        set(0, MEM_WRITE, 0, 0, 6, 32'hBB, 0, 0, '0);
        lit("hist_hit", HIST_ON ? FWD_HIST : FWD_NONE, HIST_ON ? 32'hAA : 32'hBB); cyc();

        set(0, MEM_NONE, 0, 0, 0, '0, 1, 6, 32'hAA); cyc();
        set(0, MEM_NONE, 0, 0, 0, '0, 0, 0, '0);
        repeat (HD) cyc();
        set(0, MEM_WRITE, 0, 0, 6, 32'hBB, 0, 0, '0);
        lit("hist_aged", FWD_NONE, 32'hBB); cyc();

        set(0, MEM_WRITE, 1, 0, 7, 32'h99, 1, 7, 32'h55);
        lit("stall_entry", FWD_W, 32'h55); cyc();
        for (int i = 0; i < 3; i++) begin
            set(0, MEM_WRITE, 1, 0, 7, 32'h99, 0, 0, '0);
            lit("stall_hold", FWD_HOLD, 32'h55); cyc();
        end
        set(0, MEM_WRITE, 0, 0, 7, 32'h99, 0, 0, '0);
        lit("stall_release", FWD_HOLD, 32'h55); cyc();
        set(0, MEM_WRITE, 0, 0, 7, 32'h77, 0, 0, '0);
        lit("hold_cleared", FWD_NONE, 32'h77); cyc();

        set(0, MEM_WRITE, 0, 0, 0, 32'h33, 1, 0, 32'h44);
        lit("x0_no_fwd", FWD_NONE, 32'h33); cyc();

        set(0, MEM_NONE, 0, 0, 0, '0, 1, 9, 32'h1); cyc();
        set(0, MEM_WRITE, 0, 0, 9, 32'h5, 1, 9, 32'h2);
        lit("w_over_hist", FWD_W, 32'h2); cyc();

        set(0, MEM_WRITE, 1, 0, 7, '0, 1, 7, 32'h11);
        lit("flush_setup", FWD_W, 32'h11); cyc();
        set(0, MEM_WRITE, 1, 1, 7, 32'h66, 0, 0, '0);
        lit("flush_cycle", FWD_NONE, 32'h66); cyc();
        set(0, MEM_WRITE, 1, 0, 12, 32'h0C, 0, 0, '0);
        lit("after_flush", FWD_NONE, 32'h0C); cyc();

        set(0, MEM_WRITE, 1, 0, 7, '0, 1, 7, 32'h22);
        lit("rst_setup", FWD_W, 32'h22); cyc();
        set(1, MEM_WRITE, 1, 0, 7, 32'h31, 0, 0, '0);
        lit("rst_during_stall", FWD_NONE, 32'h31); cyc();
        set(0, MEM_WRITE, 1, 0, 7, 32'h32, 0, 0, '0);
        lit("after_rst", FWD_NONE, 32'h32); cyc();

        set(0, MEM_NONE, 0, 0, 0, '0, 0, 0, '0);
        cyc(); cyc();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_data_forward_unit.md
STORE_DATA_FORWARD_UNIT -- requirements
Module: store_data_forward_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data width.
REQ-002 The block SHALL have parameter HIST_DEPTH, default 2, range 1..4, giving the number of past-writeback entries.
REQ-003 The block SHALL have these ports, clock and reset first:
- clk  in  1  single clock; one clock domain, reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- memaccess_m1  in  memaccess_t  memory access type of the M1 instruction.
- stall_m1  in  1  M1 instruction held this cycle.
- flush_m1  in  1  M1 instruction killed this cycle.
- rs2_m1  in  5  store-data source register.
- rs2_data_m1  in  XLEN  pipelined register-file value of rs2.
- regwrite_w  in  1  W stage writes the register file.
- rd_w  in  5  W destination register.
- result_w  in  XLEN  W writeback value.
- store_data_m1  out  XLEN  resolved store data.
- forward_m1  out  1  store_data_m1 comes from a non-pipelined source.
- flag  out  1  hazard-detected indication; equal to forward_m1.
- fwd_src  out  fwd_src_t  selected source.

Function
REQ-004 The block SHALL treat the store as active when memaccess_m1 == MEM_WRITE and flush_m1 == 0; when it is not active, forward_m1 = 0, flag = 0, fwd_src = FWD_NONE, and store_data_m1 = rs2_data_m1.
REQ-005 A W hit SHALL be defined as regwrite_w && rd_w != 0 && rd_w == rs2_m1.
REQ-006 Each history entry k SHALL hold {valid, rd, data} for the writeback that happened k+1 cycles ago.
REQ-007 The history SHALL shift every cycle, stall or not; entry 0 loads {regwrite_w && rd_w != 0, rd_w, result_w}; the oldest entry is discarded.
REQ-008 History entry k SHALL hit when it is valid and its rd == rs2_m1.
REQ-009 For an active store, the source SHALL be chosen in this order, highest first: W hit (FWD_W), hold register (FWD_HOLD), lowest-index history hit (FWD_HIST), rs2_data_m1 (FWD_NONE).
REQ-010 forward_m1 and flag SHALL be 1 exactly when fwd_src != FWD_NONE; both are combinational with zero latency.
REQ-011 The hold register SHALL load the selected forwarded data and set hold_valid when an active store has stall_m1 = 1 and fwd_src is FWD_W or FWD_HIST.
REQ-012 While hold_valid = 1 and stall_m1 = 1, a new W hit SHALL overwrite the hold register, because the youngest producer wins.
REQ-013 hold_valid SHALL clear on the first clock edge where stall_m1 = 0, where flush_m1 = 1, or where the store is not active; clearing takes priority over loading.
REQ-014 The hold register SHALL guarantee that a value forwarded at stall entry stays on store_data_m1 for the whole stall, even after the value ages out of the history.
REQ-015 rs2_m1 == 0 SHALL never forward; x0 writes are never recorded as valid history entries.

Reset
REQ-016 On reset, all history valid bits SHALL be 0, hold_valid SHALL be 0, and the hold data SHALL be 0.
REQ-017 During reset, the outputs SHALL follow REQ-004 and REQ-009 with empty history and an empty hold register.
REQ-018 Reset asserted in the middle of a stall SHALL discard the held data on that edge.

Configuration
REQ-019 With macro STORE_FWD_HISTORY_EN defined, the history shift register and FWD_HIST selection SHALL be built as specified.
REQ-020 Without STORE_FWD_HISTORY_EN, the block SHALL build no history, HIST_DEPTH SHALL be ignored, and the sources SHALL be only FWD_W, FWD_HOLD and FWD_NONE. The hold register remains.

Structure
REQ-021 fwd_src_t (FWD_NONE, FWD_W, FWD_HOLD, FWD_HIST) SHALL be defined in riscv_defines, alongside memaccess_t and MEM_WRITE.
REQ-022 The history SHALL be one sub-module, store_fwd_history, with parameters XLEN and HIST_DEPTH and ports for push, the lookup register, hit, and hit data. It is instantiated only under STORE_FWD_HISTORY_EN.
REQ-023 The target size SHALL be about 150-250 lines of RTL across both modules.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- W hit: store rs2 = x5, regwrite_w = 1, rd_w = 5, result_w = 0x1234 -> store_data_m1 = 0x1234, fwd_src = FWD_W, flag = 1, same cycle.
- History: W writes x6 = 0xAA in cycle n; store with rs2 = x6 in M1 in cycle n+1 -> FWD_HIST, data 0xAA. The same case in cycle n+HIST_DEPTH+1 -> FWD_NONE, data = rs2_data_m1.
- Stall hold: store rs2 = x7, W hit 0x55, stall_m1 = 1 for 4 cycles with W idle -> store_data_m1 = 0x55 and FWD_HOLD on cycles 2-4; hold_valid clears after stall_m1 drops.
- x0 and priority: rd_w = 0 with rs2 = x0 -> no forward. W hit (0x2) and history hit (0x1) together on x9 -> 0x2 from FWD_W.
- Flush and reset: hold_valid = 1, then flush_m1 = 1 -> next cycle hold_valid = 0, fwd_src = FWD_NONE. Reset during a stall -> history and hold empty next cycle.
- The bench SHALL rerun the history and x0/priority scenarios with STORE_FWD_HISTORY_EN undefined: the history scenario never reports FWD_HIST, and a history-only hit gives FWD_NONE.
